dbg_step_ctrl: RTL
==================

# dbg_step_ctrl

Board-level execution controller for the FPGA debug harness: converts raw pushbuttons and switches into a clock-enable for the single-cycle RISC-V datapath. The debug display path only observes the CPU; this block is the input side that drives it. It gives the operator single-step, free-run and N-cycle burst execution, plus a breakpoint halt. It sits between the board I/O pins and the datapath's clock-enable input.

## Interface
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required before a button level is accepted (1 ms at 100 MHz).
- CNT_W, 17: debounce counter width; must hold DEBOUNCE_CYCLES.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_step  in  1  raw pushbutton, asynchronous, active-high.
- btn_run  in  1  raw pushbutton; toggles free-run.
- btn_burst  in  1  raw pushbutton; starts a burst.
- burst_len  in  8  switch value; burst length in cycles, sampled on burst start.
- bp_hit  in  1  synchronous breakpoint indication from the datapath.
- cpu_en  out  1  datapath clock-enable, registered.
- state  out  2  FSM state: 00 IDLE, 01 STEP, 10 RUN, 11 BURST.
- step_cnt  out  16  count of cycles with cpu_en=1 since reset.
- remaining  out  8  burst cycles left, including the current one.

## Operation
- Each button uses a 2-FF synchronizer, then a debouncer. The debounced level takes the synchronized value only after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets the counter to 0.
- A rising edge of the debounced level produces a one-cycle press pulse (step_p, run_p, burst_p).
- The FSM is Moore: cpu_en=1 exactly when the registered next state is STEP, RUN or BURST.
- IDLE:
  - Simultaneous presses resolve with priority run_p > burst_p > step_p.
  - run_p -> RUN.
  - burst_p with burst_len≠0 -> BURST, remaining←burst_len. With burst_len=0, stay in IDLE.
  - step_p -> STEP.
- STEP: lasts exactly one cycle, then IDLE.
- RUN:
  - run_p or bp_hit -> IDLE.
  - step_p and burst_p are ignored.
- BURST:
  - remaining decrements each cycle.
  - When remaining=1, next state is IDLE. This gives exactly burst_len enable cycles.
  - run_p or bp_hit aborts to IDLE; remaining←0.
  - burst_len changes during a burst are ignored.
- bp_hit is ignored in IDLE and STEP.
- step_cnt increments each cycle cpu_en=1 and wraps from 0xFFFF to 0x0000.
- Reset, including mid-burst or mid-run, forces the following immediately:
  - state=IDLE, cpu_en=0, step_cnt=0, remaining=0.
  - Synchronizers, debounced levels and debounce counters cleared to 0.
  - A button held through reset release registers as a press after debounce.

## Timing
- The raw-to-press latency below is measured for a clean edge.
  - Cycles 0–2: synchronizer delay (2).
  - Cycles 2 to DEBOUNCE_CYCLES+2: debounce interval.
  - The debounced level then updates.
  - One further cycle later, the press pulse is asserted.
- The state and cpu_en update on the clock edge after the press pulse.
- cpu_en never glitches; it is a flop output.
- bp_hit sampled high in RUN/BURST at cycle t: cpu_en is still 1 during cycle t and goes to 0 from t+1.
- Back-to-back steps need a full release/press cycle of the debounced level. Holding a button never repeats.

## Configuration
- DBG_BURST_EN defined: the BURST state, the remaining counter and burst_p handling are compiled in, as described above.
- Not defined:
  - burst_p behaves as step_p, with the same priority position.
  - The remaining output is tied to 0.
  - State encoding 11 is unreachable.

## Test plan
- DEBOUNCE_CYCLES=4; btn_step pulsed high for 2 cycles -> no press; held 10 cycles -> exactly one cpu_en cycle, state 01 for one cycle, step_cnt=1.
- btn_run pressed, 20 cycles elapse, btn_run pressed again -> cpu_en high continuously between the two state changes; step_cnt equals the number of RUN cycles.
- DBG_BURST_EN, burst_len=5, btn_burst pressed -> exactly 5 cpu_en cycles, remaining shows 5,4,3,2,1, then IDLE. burst_len=0 -> no cpu_en.
- RUN, bp_hit asserted at cycle t -> cpu_en=1 at t, 0 at t+1, state=00. bp_hit in IDLE -> no effect.
- rst asserted mid-burst with remaining=3 -> cpu_en, state, step_cnt and remaining all 0 asynchronously. After release, no enable occurs until a new press.
- step_cnt preloaded near wrap via a 65535-cycle run plus 2 steps -> step_cnt reads 0x0001. Simultaneous run+step press in IDLE -> RUN.

Source files
------------

// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl: board-level execution controller for the debug harness.
// It turns the raw step/run/burst pushbuttons into a registered clock-enable
// for the single-cycle datapath, with breakpoint halt.
// Optional feature macro: DBG_BURST_EN. When it is defined, the build includes
// the BURST state and the remaining counter. Without it, the burst button acts
// as a step and remaining reads 0.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | datapath halted, waiting for a press
// STEP   | one enabled cycle, then back to IDLE
// RUN    | free-running until run press or breakpoint
// BURST  | burst_len enabled cycles, abortable (DBG_BURST_EN)
module dbg_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic        btn_burst,
  input  logic [7:0]  burst_len,
  input  logic        bp_hit,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [15:0] step_cnt,
  output logic [7:0]  remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BURST = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 step, bit 1 run, bit 2 burst
  logic [2:0] sync1, sync2;
  logic [2:0] db, db_d, press;
  logic       step_p, run_p, burst_p;
  state_t     st;

  // two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_burst, btn_run, btn_step};
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic             lvl;
    logic [CNT_W-1:0] cnt;

    // accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[g] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        lvl <= sync2[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign db[g] = lvl;
  end

  // one-cycle registered press pulse on each debounced rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_d  <= '0;
      press <= '0;
    end else begin
      db_d  <= db;
      press <= db & ~db_d;
    end
  end

  assign step_p  = press[0];
  assign run_p   = press[1];
  assign burst_p = press[2];

`ifdef DBG_BURST_EN
  logic [7:0] rem;

  // Moore FSM; cpu_en is loaded with the enable value of the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      cpu_en <= 1'b0;
      rem    <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run_p) begin
            st     <= S_RUN;
            cpu_en <= 1'b1;
          end else if (burst_p) begin
            // a zero-length burst is consumed without enabling the datapath
            if (burst_len != 8'd0) begin
              st     <= S_BURST;
              cpu_en <= 1'b1;
              rem    <= burst_len;
            end
          end else if (step_p) begin
            st     <= S_STEP;
            cpu_en <= 1'b1;
          end
        end
        S_STEP: begin
          st     <= S_IDLE;
          cpu_en <= 1'b0;
        end
        S_RUN: begin
          if (run_p || bp_hit) begin
            st     <= S_IDLE;
            cpu_en <= 1'b0;
          end
        end
        S_BURST: begin
          if (run_p || bp_hit || rem == 8'd1) begin
            st     <= S_IDLE;
            cpu_en <= 1'b0;
            rem    <= '0;
          end else begin
            rem <= rem - 8'd1;
          end
        end
        default: begin
          st     <= S_IDLE;
          cpu_en <= 1'b0;
        end
      endcase
    end
  end

  assign remaining = rem;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;

  // Moore FSM; the burst button is an alias of step in this build
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      cpu_en <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run_p) begin
            st     <= S_RUN;
            cpu_en <= 1'b1;
          end else if (burst_p || step_p) begin
            st     <= S_STEP;
            cpu_en <= 1'b1;
          end
        end
        S_STEP: begin
          st     <= S_IDLE;
          cpu_en <= 1'b0;
        end
        S_RUN: begin
          if (run_p || bp_hit) begin
            st     <= S_IDLE;
            cpu_en <= 1'b0;
          end
        end
        default: begin
          st     <= S_IDLE;
          cpu_en <= 1'b0;
        end
      endcase
    end
  end

  assign remaining = 8'd0;
`endif

  // count enabled cycles, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
    end else if (cpu_en) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

  assign state = st;

endmodule
